// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side bundle for inst_prefetch_buffer: instruction memory req/ack,
// IF-stage delivery and pipeline redirect.
interface inst_prefetch_buffer_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        output redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_inst
    );

    modport slave (
        input  redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher with a small FIFO and a registered head.
// Optional PREFETCH_PERF_EN adds saturating flush_count / drop_count outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request outstanding; waits for FIFO room
// FETCH   | request to fetch_pc outstanding, response will be queued
// DISCARD | request outstanding but redirected; response will be dropped
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    inst_prefetch_buffer_if.slave bus
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0] flush_count,
    output logic [15:0] drop_count
`endif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
    state_t state;

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          imem_req_q;
    logic [31:0]   imem_addr_q;
    logic          out_valid_q;
    logic [31:0]   out_pc_q;
    logic [31:0]   out_inst_q;

    logic          ack_seen;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [31:0]   fetch_pc_inc;
    logic [31:0]   redirect_pc_al;
    logic [31:0]   head_pc_nxt;
    logic [31:0]   head_inst_nxt;

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_inst  = out_inst_q;

    assign ack_seen       = imem_req_q & bus.imem_ack;
    assign push           = (state == FETCH) & ack_seen & ~bus.redirect;
    assign pop            = out_valid_q & bus.out_ready & ~bus.redirect;
    assign count_nxt      = count + CW'(push) - CW'(pop);
    assign rd_ptr_nxt     = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign fetch_pc_inc   = fetch_pc + 32'd4;
    assign redirect_pc_al = bus.redirect_pc & ~32'h3;

    // The next head may be the word arriving this cycle; it is forwarded into
    // the head register so out_* stay purely registered.
    always_comb begin
        head_pc_nxt   = fifo_pc[rd_ptr_nxt];
        head_inst_nxt = fifo_inst[rd_ptr_nxt];
        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_pc_nxt   = fetch_pc;
            head_inst_nxt = bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_inst[wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
        end else begin
            if (bus.redirect) begin
                fetch_pc    <= redirect_pc_al;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc_inc;
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                rd_ptr      <= rd_ptr_nxt;
                count       <= count_nxt;
                out_valid_q <= (count_nxt != '0);
                if (count_nxt != '0) begin
                    out_pc_q   <= head_pc_nxt;
                    out_inst_q <= head_inst_nxt;
                end
            end

            case (state)
                IDLE: begin
                    if (!bus.redirect && (count < CW'(DEPTH))) begin
                        state       <= FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc;
                    end
                end
                FETCH: begin
                    if (bus.redirect) begin
                        if (bus.imem_ack) begin
                            state      <= IDLE;
                            imem_req_q <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (bus.imem_ack) begin
                        if (count_nxt < CW'(DEPTH)) begin
                            imem_addr_q <= fetch_pc_inc;
                        end else begin
                            state      <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state      <= IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    logic drop_evt;
    assign drop_evt = ack_seen & ((state == DISCARD) | ((state == FETCH) & bus.redirect));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count <= '0;
            drop_count  <= '0;
        end else begin
            if (bus.redirect && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
            if (drop_evt && (drop_count != 16'hFFFF))      drop_count  <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Sits between the instruction memory and the IF stage of the 5-stage pipelined CPU.
- Fetches sequential instruction words ahead of the pipeline over a req/ack handshake with a multi-cycle instruction memory.
- Queues them in a small FIFO and presents {pc, inst} pairs to IF.
- A branch/jump redirect from the pipeline flushes the queue and restarts fetching at the new PC.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  pipeline taken branch/jump; flush and refetch.
- redirect_pc  input  32  new fetch address; valid when redirect=1.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_pc  output  32  PC of head instruction.
- out_inst  output  32  head instruction word.
- out_ready  input  1  IF consumes head this cycle; driven as ~stall.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
- Handshake:
  - At most one outstanding request.
  - imem_req and imem_addr hold stable from assertion until the cycle imem_ack=1, inclusive.
  - ack is sampled only while imem_req=1; ack while req=0 is ignored.
- Address rules:
  - fetch_pc advances by 4 on each accepted (non-discarded) response; 32-bit wrap from 32'hFFFF_FFFC to 0.
  - redirect_pc[1:0] is forced to 0.
- State machine:
  - IDLE -> FETCH when (count < DEPTH) and no redirect; drives imem_req=1, imem_addr=fetch_pc.
  - FETCH, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4.
    - Goes back-to-back (stays FETCH, req kept high with the new addr next cycle) if count after push/pop < DEPTH; else -> IDLE.
  - FETCH, redirect=1 without ack: -> DISCARD; keep req/addr stable; fetch_pc=redirect_pc; FIFO cleared.
  - FETCH, redirect=1 with ack in the same cycle: response dropped, FIFO cleared, fetch_pc=redirect_pc, -> IDLE.
  - DISCARD, imem_ack=1: drop data, -> IDLE. A further redirect in DISCARD only updates fetch_pc.
  - IDLE, redirect=1: FIFO cleared, fetch_pc=redirect_pc; request issued next cycle.
- FIFO:
  - Head is registered; out_* reflect the head with no combinational path from imem_rdata.
  - Fetch-to-out_valid latency: 1 cycle after the ack edge.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - Pop when empty is ignored.
  - Full blocks new requests only; it never cancels an outstanding one.
  - redirect has priority over push and pop: the cycle after redirect, out_valid=0 regardless of out_ready.
- out_pc/out_inst hold their last value when out_valid=0 (don't-care to IF).

Optional Feature:
- Macro PREFETCH_PERF_EN.
- Defined: adds two output ports, both cleared by rst and saturating at 16'hFFFF:
  - flush_count[15:0]: +1 per cycle with redirect=1.
  - drop_count[15:0]: +1 per discarded imem response.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then ack every request 1 cycle after req, out_ready=1:
  - out_pc sequence 0,4,8,12 with matching imem_rdata words.
  - First out_valid 3 cycles after reset release.
- out_ready=0 with DEPTH=4:
  - Exactly 4 acks accepted, then imem_req=0.
  - Raise out_ready: heads pop in order 0,4,8,12; fetching resumes at 16.
- redirect to 32'h0000_0100 while a req to 8 is pending, ack 2 cycles later:
  - Data for 8 never appears on out_*.
  - Next imem_addr=0x100; first out_pc=0x100.
- redirect and imem_ack in the same cycle:
  - Response dropped, out_valid=0 next cycle, next req addr=redirect_pc.
- redirect_pc=32'hFFFF_FFFC:
  - out_pc sequence FFFF_FFFC then 0.
- Assert rst mid-FETCH:
  - imem_req drops immediately (async); after release, imem_addr=RESET_PC.
  - With PREFETCH_PERF_EN, flush_count/drop_count read 0.
